// File: rtl/uart_lock_pkg.sv
// Shared command/response constants and parser state encoding for the
// multi-channel UART lock controller.
package uart_lock_pkg;

  localparam logic [7:0] CMD_OPEN   = 8'h41;  // 'A'
  localparam logic [7:0] CMD_CLOSE  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_ALL    = 8'h58;  // 'X'
  localparam logic [7:0] CMD_STATUS = 8'h53;  // 'S'
  localparam logic [7:0] RSP_ACK    = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR    = 8'h45;  // 'E'
  localparam logic [7:0] CH_BASE    = 8'h30;  // '0'

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_CH = 1'b1
  } parser_state_t;

endpackage

// File: rtl/lock_relock_timer.sv
// Per-channel auto-relock countdown; o_expire is high in the cycle the count goes 1->0.
module lock_relock_timer #(
  parameter int RELOCK_CYCLES = 250000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CNT_W = (RELOCK_CYCLES > 0) ? $clog2(RELOCK_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RELOCK_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  // The count is only non-zero while the channel is open: closing always clears it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == CNT_W'(1)) && !i_load && !i_clear;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: one-cycle o_Rx_DV strobe with o_Rx_Byte once the stop bit is reached.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_Clock,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP
  } rx_state_t;

  rx_state_t        r_state;
  logic             r_rx;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;

  always_ff @(posedge i_Clock) begin
    r_rx <= i_Rx_Serial;
  end

  always_ff @(posedge i_Clock) begin
    case (r_state)
      S_IDLE: begin
        o_Rx_DV   <= 1'b0;
        r_clk_cnt <= '0;
        r_bit_idx <= '0;
        if (!r_rx) r_state <= S_START;
      end
      // Confirm the start bit half a bit later to reject glitches.
      S_START: begin
        if (r_clk_cnt == HALF) begin
          r_clk_cnt <= '0;
          r_state   <= r_rx ? S_IDLE : S_DATA;
        end else begin
          r_clk_cnt <= r_clk_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_clk_cnt < LAST) begin
          r_clk_cnt <= r_clk_cnt + CNT_W'(1);
        end else begin
          r_clk_cnt            <= '0;
          o_Rx_Byte[r_bit_idx] <= r_rx;
          if (r_bit_idx < 3'd7) begin
            r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_bit_idx <= '0;
            r_state   <= S_STOP;
          end
        end
      end
      S_STOP: begin
        if (r_clk_cnt < LAST) begin
          r_clk_cnt <= r_clk_cnt + CNT_W'(1);
        end else begin
          o_Rx_DV   <= 1'b1;
          r_clk_cnt <= '0;
          r_state   <= S_CLEANUP;
        end
      end
      S_CLEANUP: begin
        o_Rx_DV <= 1'b0;
        r_state <= S_IDLE;
      end
      default: r_state <= S_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_multilock_control.sv
// UART command parser driving NUM_LOCKS lock outputs with auto-relock and a
// one-deep, last-wins response slot feeding an external uart_tx.
module uart_multilock_control
  import uart_lock_pkg::*;
#(
  parameter int CLKS_PER_BIT         = 434,
  parameter int NUM_LOCKS            = 4,
  parameter int RELOCK_CYCLES        = 250000000,
  parameter int FRAME_TIMEOUT_CYCLES = 5000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  input  logic                 tx_busy,
  output logic [NUM_LOCKS-1:0] lock_open,
  output logic                 tx_dv,
  output logic [7:0]           tx_byte,
  output logic                 frame_err
);

  localparam int GAP_W = $clog2(FRAME_TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CH_END = CH_BASE + 8'(NUM_LOCKS);

  logic                 w_rx_dv;
  logic [7:0]           w_rx_byte;
  logic [7:0]           w_ch_idx;
  logic                 w_ch_ok;
  logic [7:0]           w_status;
  logic                 w_rsp_vld;
  logic [7:0]           w_rsp_byte;
  logic                 w_err;
  logic [NUM_LOCKS-1:0] w_open_set;
  logic [NUM_LOCKS-1:0] w_close_set;
  logic [NUM_LOCKS-1:0] w_expire;
  logic                 w_tx_fire;

  parser_state_t        r_state, w_state_nxt;
  logic [7:0]           r_cmd, w_cmd_nxt;
  logic [GAP_W-1:0]     r_gap, w_gap_nxt;
  logic [NUM_LOCKS-1:0] r_lock;
  logic                 r_slot_full;
  logic [7:0]           r_slot_byte;
  logic                 r_tx_dv;
  logic [7:0]           r_tx_byte;
  logic                 r_frame_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_Clock     (clk),
    .i_Rx_Serial (rx_pin),
    .o_Rx_DV     (w_rx_dv),
    .o_Rx_Byte   (w_rx_byte)
  );

  for (genvar g = 0; g < NUM_LOCKS; g++) begin : g_timer
    lock_relock_timer #(.RELOCK_CYCLES(RELOCK_CYCLES)) u_timer (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_load   (w_open_set[g]),
      .i_clear  (w_close_set[g]),
      .o_expire (w_expire[g])
    );
  end

  assign w_ch_idx  = w_rx_byte - CH_BASE;
  assign w_ch_ok   = (w_rx_byte >= CH_BASE) && (w_rx_byte < CH_END);
  assign w_status  = 8'h80 | 8'(r_lock);
  assign w_tx_fire = r_slot_full && !tx_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_gap_nxt   = r_gap;
    w_open_set  = '0;
    w_close_set = '0;
    w_rsp_vld   = 1'b0;
    w_rsp_byte  = RSP_ACK;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rx_dv) begin
          case (w_rx_byte)
            CMD_OPEN, CMD_CLOSE: begin
              w_cmd_nxt   = w_rx_byte;
              w_gap_nxt   = GAP_W'(FRAME_TIMEOUT_CYCLES);
              w_state_nxt = WAIT_CH;
            end
            CMD_ALL: begin
              w_close_set = '1;
              w_rsp_vld   = 1'b1;
            end
            CMD_STATUS: begin
              w_rsp_vld  = 1'b1;
              w_rsp_byte = w_status;
            end
            default: ;
          endcase
        end
      end
      WAIT_CH: begin
        if (w_rx_dv) begin
          w_state_nxt = IDLE;
          w_rsp_vld   = 1'b1;
          if (w_ch_ok) begin
            for (int i = 0; i < NUM_LOCKS; i++) begin
              if (w_ch_idx == 8'(i)) begin
                w_open_set[i]  = (r_cmd == CMD_OPEN);
                w_close_set[i] = (r_cmd != CMD_OPEN);
              end
            end
          end else begin
            w_rsp_byte = RSP_ERR;
            w_err      = 1'b1;
          end
        end else if (r_gap == GAP_W'(1)) begin
          w_state_nxt = IDLE;
          w_rsp_vld   = 1'b1;
          w_rsp_byte  = RSP_ERR;
          w_err       = 1'b1;
        end else begin
          w_gap_nxt = r_gap - GAP_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cmd       <= 8'h00;
      r_gap       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd       <= w_cmd_nxt;
      r_gap       <= w_gap_nxt;
      r_frame_err <= w_err;
    end
  end

  // Explicit open beats a same-cycle expiry; close and expiry both close.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock <= '0;
    end else begin
      r_lock <= (r_lock & ~w_close_set & ~w_expire) | w_open_set;
    end
  end

  // A new response overwrites the slot even while the old one drains to tx_byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_full <= 1'b0;
      r_slot_byte <= 8'h00;
      r_tx_dv     <= 1'b0;
      r_tx_byte   <= 8'h00;
    end else begin
      r_tx_dv <= w_tx_fire;
      if (w_tx_fire) r_tx_byte <= r_slot_byte;
      if (w_rsp_vld) begin
        r_slot_full <= 1'b1;
        r_slot_byte <= w_rsp_byte;
      end else if (w_tx_fire) begin
        r_slot_full <= 1'b0;
      end
    end
  end

  assign lock_open = r_lock;
  assign tx_dv     = r_tx_dv;
  assign tx_byte   = r_tx_byte;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_multilock_control.sv
// Serial-stimulus bench for uart_multilock_control with a deadline-based reference model.
module tb_uart_multilock_control;

  localparam int CPB     = 4;
  localparam int NL      = 4;
  localparam int RELOCK  = 100;
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic       tx_busy = 1'b0;
  logic [3:0] lock_open;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       frame_err;

  uart_multilock_control #(
    .CLKS_PER_BIT(CPB), .NUM_LOCKS(NL),
    .RELOCK_CYCLES(RELOCK), .FRAME_TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .rx_pin(rx_pin), .tx_busy(tx_busy),
    .lock_open(lock_open), .tx_dv(tx_dv), .tx_byte(tx_byte), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: lock state with absolute close deadlines, frame state, response slot.
  logic [3:0] m_lock;
  int         m_deadline[NL];
  bit         m_wait;
  logic [7:0] m_cmd;
  int         m_wait_start;
  bit         m_slot_full;
  logic [7:0] m_slot;
  bit         m_txdv;
  logic [7:0] m_txbyte;
  bit         m_ferr;
  int         cyc = 0;
  int         rx_cyc = 0;
  int         n_txdv = 0;
  int         n_ferr = 0;
  logic [7:0] sent_q[$];

  task automatic model_reset();
    m_lock = '0; m_wait = 0; m_cmd = 8'h00; m_wait_start = 0;
    m_slot_full = 0; m_slot = 8'h00; m_txdv = 0; m_txbyte = 8'h00; m_ferr = 0;
    for (int i = 0; i < NL; i++) m_deadline[i] = 0;
  endtask

  task automatic model_step(input bit evt, input logic [7:0] b);
    logic [3:0] nl;
    bit         rsp;
    logic [7:0] rbyte;
    int         idx;
    nl = m_lock; rsp = 0; rbyte = 8'h00; m_ferr = 0;
    for (int i = 0; i < NL; i++)
      if (nl[i] && m_deadline[i] == cyc + 1) nl[i] = 1'b0;
    if (m_slot_full && !tx_busy) begin
      m_txdv = 1; m_txbyte = m_slot; m_slot_full = 0;
    end else begin
      m_txdv = 0;
    end
    if (evt && !m_wait) begin
      if (b == 8'h41 || b == 8'h43) begin
        m_wait = 1; m_cmd = b; m_wait_start = cyc + 1;
      end else if (b == 8'h58) begin
        nl = '0; rsp = 1; rbyte = 8'h4B;
      end else if (b == 8'h53) begin
        rsp = 1; rbyte = 8'h80 | {4'h0, m_lock};
      end
    end else if (evt) begin
      m_wait = 0; rsp = 1;
      if (b >= 8'h30 && b < 8'h30 + NL) begin
        idx = int'(b) - 48;
        if (m_cmd == 8'h41) begin
          nl[idx] = 1'b1; m_deadline[idx] = cyc + 1 + RELOCK;
        end else begin
          nl[idx] = 1'b0;
        end
        rbyte = 8'h4B;
      end else begin
        rbyte = 8'h45; m_ferr = 1;
      end
    end else if (m_wait && cyc + 1 == m_wait_start + TIMEOUT) begin
      m_wait = 0; rsp = 1; rbyte = 8'h45; m_ferr = 1;
    end
    if (rsp) begin
      m_slot = rbyte; m_slot_full = 1;
    end
    m_lock = nl;
  endtask

  // Monitor runs just before each rising edge: outputs settled, inputs about to be sampled.
  initial begin
    logic [7:0] rb;
    bit         evt;
    forever begin
      @(negedge clk); #4;
      cyc++;
      evt = dut.w_rx_dv;
      rb  = dut.w_rx_byte;
      if (evt) begin
        rx_cyc = cyc;
        if (sent_q.size() > 0) begin
          check_eq("rx_byte", rb, sent_q[0]);
          rb = sent_q.pop_front();
        end else begin
          check_eq("rx_unexpected_byte", 32'(sent_q.size()), 32'd1);
        end
      end
      if (rst) begin
        model_reset();
      end else begin
        check_eq("lock_open", 32'(lock_open), 32'(m_lock));
        check_eq("tx_dv", tx_dv, m_txdv);
        check_eq("tx_byte", tx_byte, m_txbyte);
        check_eq("frame_err", frame_err, m_ferr);
        if (tx_dv) n_txdv++;
        if (frame_err) n_ferr++;
        model_step(evt, rb);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    sent_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_pin = frame[i];
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    int         t0, r1, f1, base_tx, base_fe, tmo;
    logic [3:0] snap;
    logic [7:0] b;
    bit         found;

    // Reset state
    wait_cyc(5);
    check_eq("rst_lock_open", 32'(lock_open), 32'd0);
    check_eq("rst_tx_dv", tx_dv, 1'b0);
    check_eq("rst_tx_byte", tx_byte, 8'h00);
    check_eq("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    wait_cyc(10);

    // "A2" opens channel 2 with one ACK; auto-relock later, no extra tx_dv
    base_tx = n_txdv;
    send_byte(8'h41); send_byte(8'h32);
    wait_cyc(10);
    check_eq("a2_lock_open", 32'(lock_open), 32'h4);
    check_eq("a2_tx_byte", tx_byte, 8'h4B);
    check_eq("a2_tx_count", 32'(n_txdv - base_tx), 32'd1);
    wait_cyc(120);
    check_eq("a2_relocked", 32'(lock_open), 32'h0);
    check_eq("a2_no_extra_tx", 32'(n_txdv - base_tx), 32'd1);

    // "A0" closes exactly RELOCK cycles after it opens
    send_byte(8'h41); send_byte(8'h30);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin wait_cyc(1); found = lock_open[0]; end
    check_eq("a0_open_seen", found, 1'b1);
    r1 = cyc + 1;
    found = 0;
    for (int i = 0; i < 150 && !found; i++) begin wait_cyc(1); found = !lock_open[0]; end
    check_eq("a0_close_seen", found, 1'b1);
    f1 = cyc + 1;
    check_eq("a0_open_time", 32'(f1 - r1), 32'(RELOCK));

    // Re-sending "A0" while open reloads the counter
    send_byte(8'h41); send_byte(8'h30);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin wait_cyc(1); found = lock_open[0]; end
    r1 = cyc + 1;
    send_byte(8'h41); send_byte(8'h30);
    wait_cyc(3);
    t0 = rx_cyc;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin wait_cyc(1); found = !lock_open[0]; end
    check_eq("a0_reload_close_seen", found, 1'b1);
    f1 = cyc + 1;
    check_eq("a0_reload_time", 32'(f1 - t0), 32'(RELOCK + 1));
    check_eq("a0_reload_extended", 32'(f1 - r1 > RELOCK), 32'd1);

    // Out-of-range channel byte
    snap = lock_open; base_fe = n_ferr;
    send_byte(8'h41); send_byte(8'h39);
    wait_cyc(10);
    check_eq("a9_lock_unchanged", 32'(lock_open), 32'(snap));
    check_eq("a9_frame_err", 32'(n_ferr - base_fe), 32'd1);
    check_eq("a9_tx_byte", tx_byte, 8'h45);

    // Lone 'A' times out after the frame gap
    send_byte(8'h41);
    wait_cyc(3);
    t0 = rx_cyc;
    found = 0;
    for (int i = 0; i < 260 && !found; i++) begin wait_cyc(1); found = frame_err; end
    check_eq("timeout_seen", found, 1'b1);
    tmo = cyc + 1;
    check_eq("timeout_time", 32'(tmo - t0), 32'(TIMEOUT + 1));
    wait_cyc(4);
    check_eq("timeout_tx_byte", tx_byte, 8'h45);
    send_byte(8'h53);
    wait_cyc(10);
    check_eq("idle_after_timeout_status", tx_byte, 8'h80);

    // Channels 1 and 3 opened, then status; ch1 has already timed out by the time 'S' lands
    send_byte(8'h41); send_byte(8'h31);
    send_byte(8'h41); send_byte(8'h33);
    send_byte(8'h53);
    wait_cyc(10);
    check_eq("status_tx_byte", tx_byte, 8'h88);
    send_byte(8'h58);
    wait_cyc(10);
    check_eq("x_lock_open", 32'(lock_open), 32'h0);
    check_eq("x_tx_byte", tx_byte, 8'h4B);

    // Responses while tx_busy: last wins, single tx_dv afterwards
    tx_busy = 1'b1;
    base_tx = n_txdv;
    send_byte(8'h41); send_byte(8'h31);
    send_byte(8'h53);
    wait_cyc(10);
    check_eq("busy_no_tx", 32'(n_txdv - base_tx), 32'd0);
    tx_busy = 1'b0;
    wait_cyc(10);
    check_eq("busy_single_tx", 32'(n_txdv - base_tx), 32'd1);
    check_eq("busy_last_wins", tx_byte, 8'h82);
    wait_cyc(100);

    // Asynchronous reset mid-frame with lock 2 open
    send_byte(8'h41); send_byte(8'h32);
    send_byte(8'h41);
    wait_cyc(8);
    check_eq("pre_rst_lock2", lock_open[2], 1'b1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_lock_open", 32'(lock_open), 32'h0);
    check_eq("async_rst_tx_dv", tx_dv, 1'b0);
    wait_cyc(3);
    rst = 1'b0;
    send_byte(8'h43); send_byte(8'h32);
    wait_cyc(10);
    check_eq("post_rst_c2_ack", tx_byte, 8'h4B);
    check_eq("post_rst_lock_open", 32'(lock_open), 32'h0);

    // Randomized frames, model checks every cycle
    for (int f = 0; f < 150; f++) begin
      tx_busy = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          send_byte(8'h41); send_byte(8'h30 + 8'($urandom_range(0, 5)));
        end
        3, 4: begin
          send_byte(8'h43); send_byte(8'h30 + 8'($urandom_range(0, 5)));
        end
        5: send_byte(8'h58);
        6: send_byte(8'h53);
        7: begin
          b = 8'($urandom_range(0, 255));
          send_byte(b);
        end
        8: begin
          send_byte(8'h41);
          wait_cyc(TIMEOUT + 10);
        end
        default: wait_cyc($urandom_range(0, 120));
      endcase
      wait_cyc($urandom_range(0, 20));
    end
    tx_busy = 1'b0;
    wait_cyc(TIMEOUT + RELOCK + 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
